multi_channel_dac: RTL and testbench

//  Synthesisable N-channel sample-and-hold DAC front end; successor to the sim-only stereo sample logger.

---
 rtl/dac_pkg.sv | 5 +
 rtl/sample_timer.sv | 26 ++
 rtl/multi_channel_dac.sv | 106 ++++++++++
 tb/tb_multi_channel_dac.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Modulator mode constants shared by the channel mixer and the DAC front end.
package dac_pkg;
   localparam int MODE_PWM = 0;
   localparam int MODE_SDM = 1;
endpackage

// File: rtl/sample_timer.sv
// Sample-period timer: counts 0..PERIOD-1 and emits a registered 1-cycle tick on wrap.
module sample_timer #(
   parameter int PERIOD = 128
) (
   input  logic clk,
   input  logic rst,
   output logic tick,
   output logic wrap
);
   localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   logic [CW-1:0] cnt;

   // wrap is the combinational "last count" so callers can load data on the same edge that raises tick
   assign wrap = (cnt == CW'(PERIOD - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= wrap;
         cnt  <= wrap ? '0 : cnt + 1'b1;
      end
   end
endmodule

// File: rtl/multi_channel_dac.sv
// N-channel sample-and-hold DAC front end: latches one sample per channel each period
// and drives a 1-bit PWM or first-order sigma-delta stream per channel.
module multi_channel_dac
   import dac_pkg::*;
#(
   parameter int CHANNELS    = 2,
   parameter int WIDTH       = 4,
   parameter int SAMPLE_TIME = 128,
   parameter int MODE        = 0,
   parameter int SIM_LOG     = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] samples,
   input  logic                      mute,
   output logic                      sample_tick,
   output logic [CHANNELS*WIDTH-1:0] held,
   output logic [CHANNELS-1:0]       dac_out
);
   generate
      if (CHANNELS < 1 || WIDTH < 1 || SAMPLE_TIME < 2 || (MODE != MODE_PWM && MODE != MODE_SDM)) begin : g_bad_param
         $error("multi_channel_dac: illegal parameters CHANNELS=%0d WIDTH=%0d SAMPLE_TIME=%0d MODE=%0d",
                CHANNELS, WIDTH, SAMPLE_TIME, MODE);
      end
   endgenerate

   logic [CHANNELS-1:0][WIDTH-1:0] smp;
   logic [CHANNELS-1:0][WIDTH-1:0] held_q;
   logic                           wrap;

   assign smp  = samples;
   assign held = held_q;

   sample_timer #(.PERIOD(SAMPLE_TIME)) u_timer (
      .clk  (clk),
      .rst  (rst),
      .tick (sample_tick),
      .wrap (wrap)
   );

   always_ff @(posedge clk) begin
      if (rst)       held_q <= '0;
      else if (wrap) held_q <= mute ? '0 : smp;
   end

   generate
      if (MODE == MODE_SDM) begin : g_sdm
         for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            logic [WIDTH-1:0] acc;
            logic [WIDTH:0]   sum;
            logic             bit_q;

            assign sum        = {1'b0, acc} + {1'b0, held_q[c]};
            assign dac_out[c] = bit_q;

            // accumulator persists across ticks and mute so density tracks held without re-phasing
            always_ff @(posedge clk) begin
               if (rst) begin
                  acc   <= '0;
                  bit_q <= 1'b0;
               end else begin
                  acc   <= sum[WIDTH-1:0];
                  bit_q <= sum[WIDTH];
               end
            end
         end
      end else begin : g_pwm
         logic [WIDTH-1:0] pwm_cnt;

         always_ff @(posedge clk) begin
            if (rst) pwm_cnt <= '0;
            else     pwm_cnt <= pwm_cnt + 1'b1;
         end

         for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            logic bit_q;

            assign dac_out[c] = bit_q;

            always_ff @(posedge clk) begin
               if (rst) bit_q <= 1'b0;
               else     bit_q <= (pwm_cnt < held_q[c]);
            end
         end
      end
   endgenerate

`ifndef SYNTHESIS
   generate
      if (SIM_LOG != 0) begin : g_log
         int unsigned log_n;

         always @(posedge clk) begin
            if (rst) begin
               log_n <= 0;
            end else if (sample_tick) begin
               $write("%0d", log_n);
               for (int c = 0; c < CHANNELS; c++) $write(" %0d", held_q[c]);
               $write("\n");
               log_n <= log_n + 1;
            end
         end
      end
   endgenerate
`endif
endmodule

// File: tb/tb_multi_channel_dac.sv
// Directed bench: a 3-channel PWM instance and a 2-channel sigma-delta instance, both with an 8-cycle period.
module tb_multi_channel_dac;
   logic        clk = 1'b0;
   logic        rst;
   logic        mute;
   logic [11:0] smp_p;
   logic [7:0]  smp_s;
   logic        tick_p, tick_s;
   logic [11:0] held_p;
   logic [7:0]  held_s;
   logic [2:0]  dac_p;
   logic [1:0]  dac_s;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multi_channel_dac #(.CHANNELS(3), .WIDTH(4), .SAMPLE_TIME(8), .MODE(0), .SIM_LOG(0)) u_pwm (
      .clk(clk), .rst(rst), .samples(smp_p), .mute(mute),
      .sample_tick(tick_p), .held(held_p), .dac_out(dac_p)
   );

   multi_channel_dac #(.CHANNELS(2), .WIDTH(4), .SAMPLE_TIME(8), .MODE(1), .SIM_LOG(0)) u_sdm (
      .clk(clk), .rst(rst), .samples(smp_s), .mute(mute),
      .sample_tick(tick_s), .held(held_s), .dac_out(dac_s)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // one posedge, then settle before sampling
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tick(input bit use_sdm, input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step();
         seen = use_sdm ? tick_s : tick_p;
      end
      chk({tag, "_timeout"}, {31'd0, seen}, 32'd1);
   endtask

   initial begin
      int n_ticks, gap_bad, last_edge;
      int hi0, hi1, hi2;
      logic [7:0] pat0, pat1;

      // 1: reset holds everything at 0 with full-scale samples applied
      rst = 1'b1; mute = 1'b0; smp_p = 12'hFFF; smp_s = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_held", {20'd0, held_p}, 32'd0);
         chk("rst_dac", {29'd0, dac_p}, 32'd0);
         chk("rst_tick", {31'd0, tick_p}, 32'd0);
      end
      rst = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         step();
         chk("pre_tick", {31'd0, tick_p}, 32'd0);
      end
      step();
      chk("first_tick", {31'd0, tick_p}, 32'd1);
      chk("first_held", {20'd0, held_p}, 32'hFFF);

      // 2: 80 cycles -> 10 ticks spaced 8 apart
      n_ticks = 0; gap_bad = 0; last_edge = 0;
      for (int e = 1; e <= 80; e++) begin
         step();
         if (tick_p) begin
            n_ticks++;
            if (e - last_edge != 8) gap_bad++;
            last_edge = e;
         end
      end
      chk("tick_count", n_ticks, 32'd10);
      chk("tick_gap", gap_bad, 32'd0);

      // reset 5 cycles into a period restarts the count
      for (int e = 0; e < 5; e++) step();
      rst = 1'b1;
      step();
      chk("midrst_held", {20'd0, held_p}, 32'd0);
      chk("midrst_tick", {31'd0, tick_p}, 32'd0);
      rst = 1'b0;
      n_ticks = 0;
      for (int e = 1; e <= 7; e++) begin
         step();
         if (tick_p) n_ticks++;
      end
      chk("midrst_early", n_ticks, 32'd0);
      step();
      chk("midrst_tick8", {31'd0, tick_p}, 32'd1);

      // 4: sigma-delta from cleared accumulators; ch0=4, ch1=8
      smp_s = {4'd8, 4'd4};
      rst = 1'b1;
      step();
      rst = 1'b0;
      wait_tick(1'b1, "sdm_tick");
      chk("sdm_held", {24'd0, held_s}, 32'h84);
      pat0 = '0; pat1 = '0;
      for (int i = 0; i < 8; i++) begin
         step();
         pat0 = {pat0[6:0], dac_s[0]};
         pat1 = {pat1[6:0], dac_s[1]};
      end
      chk("sdm_h4", {24'd0, pat0}, 32'b0001_0001);
      chk("sdm_h8", {24'd0, pat1}, 32'b0101_0101);
      smp_s = 8'h00;
      wait_tick(1'b1, "sdm_tick0");
      chk("sdm_held0", {24'd0, held_s}, 32'd0);
      hi0 = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (i >= 1) hi0 += dac_s[0] + dac_s[1];
      end
      chk("sdm_zero", hi0, 32'd0);

      // 3: PWM duty ch0=5 ch1=0 ch2=15
      smp_p = {4'd15, 4'd0, 4'd5};
      wait_tick(1'b0, "pwm_tick");
      step();
      hi0 = 0; hi1 = 0; hi2 = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         hi0 += dac_p[0]; hi1 += dac_p[1]; hi2 += dac_p[2];
      end
      chk("pwm_h5", hi0, 32'd5);
      chk("pwm_h0", hi1, 32'd0);
      chk("pwm_h15", hi2, 32'd15);

      // 5: three independent channels ch2=0 ch1=9 ch0=3
      smp_p = 12'h093;
      wait_tick(1'b0, "ch3_tick");
      chk("ch3_held", {20'd0, held_p}, 32'h093);
      step();
      hi0 = 0; hi1 = 0; hi2 = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         hi0 += dac_p[0]; hi1 += dac_p[1]; hi2 += dac_p[2];
      end
      chk("ch3_d0", hi0, 32'd3);
      chk("ch3_d1", hi1, 32'd9);
      chk("ch3_d2", hi2, 32'd0);

      // 6: mid-period sample change and mute only take effect at the next tick
      wait_tick(1'b0, "mute_sync");
      chk("mute_base", {20'd0, held_p}, 32'h093);
      step();
      chk("tick_1cyc", {31'd0, tick_p}, 32'd0);
      step();
      smp_p = 12'h00C;
      step();
      chk("chg_hold", {20'd0, held_p}, 32'h093);
      mute = 1'b1;
      step();
      chk("mute_hold", {20'd0, held_p}, 32'h093);
      wait_tick(1'b0, "mute_tick");
      chk("mute_held", {20'd0, held_p}, 32'd0);
      step();
      chk("mute_dac", {29'd0, dac_p}, 32'd0);
      hi0 = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         hi0 += dac_p[0] + dac_p[1] + dac_p[2];
      end
      chk("mute_quiet", hi0, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
